// File: rtl/iq_capture_buffer.sv
// iq_capture_buffer: arms on start, skips a number of valid I/Q samples,
// then stores N (optionally decimated) samples into an internal RAM that is
// read back in order through rd_en with one cycle of latency.
module iq_capture_buffer #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 64,
  parameter  int SKIP_W = 16,
  parameter  int DEC_W  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_in,
  input  logic [DATA_W-1:0] q_in,
  input  logic              in_valid,
  input  logic              start,
  input  logic [ADDR_W:0]   num_samples,
  input  logic [SKIP_W-1:0] skip,
  input  logic [DEC_W-1:0]  decim,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_i,
  output logic [DATA_W-1:0] rd_q,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [DEC_W-1:0]    decim_q, decim_d;
  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic [DEC_W-1:0]    dec_cnt_q, dec_cnt_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_i_q, rd_i_d;
  logic [DATA_W-1:0]   rd_q_q, rd_q_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_en;
  logic [2*DATA_W-1:0] mem [DEPTH];

  // Next-state, counters, write strobe and read-port data
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    decim_d    = decim_q;
    skip_cnt_d = skip_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = 1'b0;
    rd_i_d     = rd_i_q;
    rd_q_d     = rd_q_q;
    wr_en      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // start outranks a simultaneous read in DONE
        if (start) begin
          n_d        = (num_samples == '0 || num_samples > DEPTH_C) ? DEPTH_C : num_samples;
          decim_d    = decim;
          skip_cnt_d = skip;
          dec_cnt_d  = '0;
          count_d    = '0;
          rd_ptr_d   = '0;
          state_d    = (skip != '0) ? S_SKIP : S_CAPTURE;
        end else if (state_q == S_DONE && rd_en && rd_ptr_q < count_q) begin
          rd_i_d     = mem[rd_ptr_q[ADDR_W-1:0]][2*DATA_W-1:DATA_W];
          rd_q_d     = mem[rd_ptr_q[ADDR_W-1:0]][DATA_W-1:0];
          rd_ptr_d   = rd_ptr_q + 1'b1;
          rd_valid_d = 1'b1;
        end
      end
      S_SKIP: begin
        if (in_valid) begin
          skip_cnt_d = skip_cnt_q - 1'b1;
          if (skip_cnt_q == SKIP_W'(1)) state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (in_valid) begin
          dec_cnt_d = (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + 1'b1;
          if (dec_cnt_q == '0) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
            if (count_d == n_q) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SKIP) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      decim_q    <= '0;
      skip_cnt_q <= '0;
      dec_cnt_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_i_q     <= '0;
      rd_q_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      decim_q    <= decim_d;
      skip_cnt_q <= skip_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_i_q     <= rd_i_d;
      rd_q_q     <= rd_q_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Capture RAM: contents survive reset, writes are suppressed during reset
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[count_q[ADDR_W-1:0]] <= {i_in, q_in};
  end

  assign rd_i     = rd_i_q;
  assign rd_q     = rd_q_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_iq_capture_buffer.sv
// Bench for iq_capture_buffer: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_iq_capture_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] i_in, q_in;
  logic              in_valid, start, rd_en;
  logic [ADDR_W:0]   num_samples;
  logic [15:0]       skip;
  logic [7:0]        decim;
  logic [DATA_W-1:0] rd_i, rd_q;
  logic              rd_valid, busy, done;
  logic [ADDR_W:0]   count;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  bit armed  = 1'b0;

  iq_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKIP_W(16), .DEC_W(8)) dut (
    .clk(clk), .reset(reset), .i_in(i_in), .q_in(q_in), .in_valid(in_valid),
    .start(start), .num_samples(num_samples), .skip(skip), .decim(decim),
    .rd_en(rd_en), .rd_i(rd_i), .rd_q(rd_q), .rd_valid(rd_valid),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 skipping, 2 capturing, 3 holding data
  int          m_phase = 0;
  int          m_n, m_skip, m_decim, m_vidx, m_rdidx;
  logic [31:0] m_cap[$];
  logic        e_rd_valid = 1'b0;
  logic [15:0] e_rd_i = '0, e_rd_q = '0;

  always @(posedge clk) begin
    armed <= 1'b1;
    if (reset) begin
      m_phase = 0; m_cap.delete(); m_rdidx = 0;
      e_rd_valid = 1'b0; e_rd_i = '0; e_rd_q = '0;
    end else begin
      e_rd_valid = 1'b0;
      if ((m_phase == 0 || m_phase == 3) && start) begin
        m_n     = (num_samples == 0 || int'(num_samples) > DEPTH) ? DEPTH : int'(num_samples);
        m_skip  = int'(skip);
        m_decim = int'(decim);
        m_vidx  = 0;
        m_rdidx = 0;
        m_cap.delete();
        m_phase = (m_skip != 0) ? 1 : 2;
      end else if (m_phase == 3 && rd_en && m_rdidx < m_cap.size()) begin
        e_rd_i     = m_cap[m_rdidx][31:16];
        e_rd_q     = m_cap[m_rdidx][15:0];
        e_rd_valid = 1'b1;
        m_rdidx++;
      end else if (m_phase == 1 && in_valid) begin
        m_skip--;
        if (m_skip == 0) m_phase = 2;
      end else if (m_phase == 2 && in_valid) begin
        if (m_vidx % (m_decim + 1) == 0) begin
          m_cap.push_back({i_in, q_in});
          if (m_cap.size() == m_n) m_phase = 3;
        end
        m_vidx++;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("busy",     int'(busy),     int'(m_phase == 1 || m_phase == 2));
      chk("done",     int'(done),     int'(m_phase == 3));
      chk("count",    int'(count),    m_cap.size());
      chk("rd_valid", int'(rd_valid), int'(e_rd_valid));
      chk("rd_i",     int'(rd_i),     int'(e_rd_i));
      chk("rd_q",     int'(rd_q),     int'(e_rd_q));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v);
    in_valid = v;
    i_in     = 16'(n);
    q_in     = 16'(-n);
    n++;
  endtask

  task automatic arm(input int ns, input int sk, input int dc, input int first);
    start       = 1'b1;
    num_samples = 7'(ns);
    skip        = 16'(sk);
    decim       = 8'(dc);
    n           = first;
    drive(1'b1);
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      drive(1'b1);
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done after %0d cycles", cycles);
    end
  endtask

  task automatic read_one(input string name, input int exp_i);
    rd_en = 1'b1;
    tick();
    chk({name, "_valid"}, int'(rd_valid), 1);
    chk({name, "_i"}, int'($signed(rd_i)), exp_i);
    chk({name, "_q"}, int'($signed(rd_q)), -exp_i);
  endtask

  int cyc;
  int t3_exp[4] = '{5, 8, 11, 14};
  int t5_exp[4] = '{200, 203, 204, 207};

  initial begin
    reset = 1'b1; in_valid = 1'b0; start = 1'b0; rd_en = 1'b0;
    i_in = '0; q_in = '0; num_samples = '0; skip = '0; decim = '0;

    // 1: reset held 10 cycles with rd_en pulsing
    for (int k = 0; k < 10; k++) begin
      rd_en = k[0];
      tick();
    end
    reset = 1'b0; rd_en = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    rd_en = 1'b1;
    tick();
    chk("idle_rd_valid", int'(rd_valid), 0);
    rd_en = 1'b0;

    // 2: N=8, no skip, no decimation; first stored sample is 101
    arm(8, 0, 0, 100);
    run_until_done(100, cyc);
    chk("t2_latency", cyc, 8);
    chk("t2_count", int'(count), 8);
    for (int k = 0; k < 8; k++) read_one("t2_rd", 101 + k);
    tick();
    chk("t2_ninth_valid", int'(rd_valid), 0);
    rd_en = 1'b0;

    // 3: N=4, skip=5, decim=2, ramp 0.. from start-cycle+1
    arm(4, 5, 2, -1);
    run_until_done(100, cyc);
    chk("t3_count", int'(count), 4);
    for (int k = 0; k < 4; k++) read_one("t3_rd", t3_exp[k]);
    rd_en = 1'b0;

    // 4: N=0 captures DEPTH samples
    arm(0, 0, 0, 1000);
    run_until_done(200, cyc);
    chk("t4_count", int'(count), 64);
    for (int k = 0; k < 64; k++) read_one("t4_rd", 1001 + k);
    tick();
    chk("t4_65th_valid", int'(rd_valid), 0);
    rd_en = 1'b0;

    // 5: gappy valid 1,0,0,1 and an ignored start during capture
    arm(4, 0, 0, 0);
    in_valid = 1'b0;
    n = 200;
    for (int p = 0; p < 8; p++) begin
      drive((p % 4 == 0) || (p % 4 == 3));
      start = (p == 2 || p == 3);
      num_samples = 7'd2; skip = 16'd3;
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    chk("t5_done", int'(done), 1);
    chk("t5_count", int'(count), 4);
    for (int k = 0; k < 4; k++) read_one("t5_rd", t5_exp[k]);
    rd_en = 1'b0;

    // 6: reset mid-capture, restart, then start+rd_en in DONE
    arm(8, 0, 0, 500);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1);
      tick();
    end
    chk("t6_mid_count", int'(count), 3);
    chk("t6_mid_busy", int'(busy), 1);
    reset = 1'b1;
    drive(1'b1);
    tick();
    reset = 1'b0;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_rd_i", int'(rd_i), 0);
    chk("t6_rst_rd_q", int'(rd_q), 0);
    arm(2, 0, 0, 300);
    run_until_done(20, cyc);
    chk("t6_count", int'(count), 2);
    read_one("t6_rd", 301);
    start = 1'b1; rd_en = 1'b1; num_samples = 7'd2; skip = '0; decim = '0;
    in_valid = 1'b0;
    tick();
    start = 1'b0; rd_en = 1'b0;
    chk("t6_rearm_rd_valid", int'(rd_valid), 0);
    chk("t6_rearm_busy", int'(busy), 1);
    n = 400;
    run_until_done(20, cyc);
    read_one("t6_new_rd", 400);
    read_one("t6_new_rd", 401);
    rd_en = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
